life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Parametrised Game of Life core: ROWS x COLS cell array, advanced one generation per accepted step request.
- Rows are processed serially, one row per clock, through a shared row-update datapath.
- Optional toroidal (wrap-around) edges, seed/clear write port, display read port, generation counter, population count, extinction/stable detection.
- Sits between the board controls (switches/buttons, clock-divider tick) and the VGA pixel path, which reads rows via rd_row/rd_data.

Parameters:
- COLS, 32, cells per row (bits per row word), >=3
- ROWS, 24, number of rows, >=3
- WRAP, 0, 1 = toroidal neighbourhood; 0 = cells outside the array read as dead
- GEN_W, 16, generation counter width
- RW, $clog2(ROWS), row index width
- PW, $clog2(ROWS*COLS+1), population count width

Ports:
- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- run_en, in, 1, level; free-run enable
- step_tick, in, 1, one-cycle pulse; run-rate tick (gated by run_en)
- single_step, in, 1, one-cycle pulse; request exactly one generation
- clear, in, 1, one-cycle pulse; zero the whole array
- seed_we, in, 1, row write strobe
- seed_row, in, RW, row address for seed write
- seed_data, in, COLS, row contents; bit j = column j
- rd_row, in, RW, display read row
- rd_data, out, COLS, registered contents of rd_row
- busy, out, 1, high while a generation is being computed
- gen_done, out, 1, one-cycle pulse when a generation commits
- gen_count, out, GEN_W, generations completed since reset/clear
- pop_count, out, PW, live cells after the last commit (or after clear/seed)
- extinct, out, 1, sticky: last commit produced zero live cells
- stable, out, 1, sticky: last commit changed no cell

Behaviour:
- Reset (async, reset_n=0): array all 0; FSM=IDLE; busy=0, gen_done=0, gen_count=0, pop_count=0, rd_data=0, extinct=0, stable=0.
- FSM states: IDLE, CALC.
- IDLE -> CALC when (step_tick & run_en & ~extinct & ~stable) | single_step. single_step ignores extinct/stable.
- Priority in IDLE, same cycle: clear > seed_we > start. A start coinciding with clear or seed_we is dropped, not queued.
- clear: array=0; gen_count=0; pop_count=0; extinct=0; stable=0. Takes effect next edge.
- seed_we (IDLE only): row seed_row <= seed_data; extinct and stable cleared; pop_count updated next cycle to the full-array popcount. Writes with seed_row >= ROWS are ignored.
- In CALC: clear, seed_we, step_tick and single_step are all ignored (dropped, no queue).
- CALC: row index r runs 0..ROWS-1, one row per cycle. busy=1 for exactly ROWS cycles.
- In-place update. A prev-row buffer holds the old row r-1. A first-row buffer holds old row 0, captured at r=0.
- Row r neighbours:
  - above = old row r-1 (prev buffer; at r=0: row ROWS-1 if WRAP, else 0)
  - below = old row r+1 (array; at r=ROWS-1: first-row buffer if WRAP, else 0)
  - Column neighbours j-1/j+1 wrap modulo COLS if WRAP, else 0 outside 0..COLS-1.
- Rule B3/S23: next=1 iff count==3, or (count==2 and cell==1). Count is 0..8, 4-bit.
- Per-row popcount is accumulated; a change flag is ORed from (new row != old row).
- On the last CALC cycle the row is written and the FSM returns to IDLE.
- Same edge: gen_done=1 for one cycle, gen_count+1 (wraps at 2^GEN_W), pop_count=accumulated total, extinct=(total==0), stable=~changed.
- Latency: start accepted at edge N -> gen_done high in cycle N+ROWS.
- rd_data: registered, one-cycle latency from rd_row; rd_row >= ROWS returns 0.
- During CALC, rd_data may mix generations. Display logic issues step_tick in vblank so that ROWS cycles complete before active video.
- Reset mid-CALC: array zeroed immediately; no gen_done; counters cleared.

Test Plan:
- Vertical blinker at (r=5..7, c=10), WRAP=0, single_step -> horizontal row 6 cols 9..11; busy high 24 cycles; gen_done one cycle later; gen_count=1; pop=3; stable=0.
- Glider at top-left, WRAP=1, run_en=1, 4*ROWS*COLS/... ticks -> pattern reappears shifted, crosses the bottom/right edge into row 0/col 0 intact; pop_count stays 5 every gen.
- Same glider, WRAP=0, run until it hits the corner -> it degrades into a 2x2 block; stable=1 and further step_tick ignored; single_step still yields gen_done with gen_count+1.
- Single live cell, run_en=1, step_tick -> pop_count=0, extinct=1; later step_ticks ignored; seed_we clears extinct.
- seed_we and clear pulsed mid-CALC -> array unaffected; start pulse simultaneous with clear in IDLE -> array cleared, no busy.
- reset_n low at r=10 of CALC -> all outputs 0 asynchronously; rd_data of any row = 0 after release.

Source files
------------

// File: rtl/life_engine.sv
// Game of Life core: ROWS x COLS array, one generation per accepted start, one row per clock.
// Start accepted at edge N -> gen_done in cycle N+ROWS; inputs arriving during CALC are dropped.
module life_engine #(
  parameter int COLS  = 32,
  parameter int ROWS  = 24,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16,
  parameter int RW    = $clog2(ROWS),
  parameter int PW    = $clog2(ROWS*COLS+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_en,
  input  logic             step_tick,
  input  logic             single_step,
  input  logic             clear,
  input  logic             seed_we,
  input  logic [RW-1:0]    seed_row,
  input  logic [COLS-1:0]  seed_data,
  input  logic [RW-1:0]    rd_row,
  output logic [COLS-1:0]  rd_data,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count,
  output logic [PW-1:0]    pop_count,
  output logic             extinct,
  output logic             stable
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [RW:0]   ROWS_L   = (RW+1)'(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
  localparam logic          WRAP_B   = (WRAP != 0);

  state_t            r_state, w_state_nxt;
  logic [COLS-1:0]   r_mem [ROWS];
  logic [COLS-1:0]   r_prev, r_first, r_rd;
  logic [RW-1:0]     r_row;
  logic [PW-1:0]     r_acc, r_pop;
  logic [GEN_W-1:0]  r_gen;
  logic              r_chg, r_pop_pend, r_gen_done, r_ext, r_stb;

  logic              w_start, w_seed_ok, w_last, w_first_row, w_chg_tot;
  logic [COLS-1:0]   w_cur, w_above, w_below, w_new;
  logic [COLS-1:0]   w_al, w_ar, w_cl, w_cr, w_bl, w_br;
  logic [PW-1:0]     w_row_pop, w_total, w_full_pop;

  assign w_start     = (step_tick & run_en & ~r_ext & ~r_stb) | single_step;
  assign w_seed_ok   = seed_we && ({1'b0, seed_row} < ROWS_L);
  assign w_last      = (r_row == LAST_ROW);
  assign w_first_row = (r_row == '0);

  // Row above comes from the prev buffer because row r-1 has already been overwritten.
  assign w_cur   = r_mem[r_row];
  assign w_above = w_first_row ? (WRAP_B ? r_mem[ROWS-1] : '0) : r_prev;
  assign w_below = w_last ? (WRAP_B ? r_first : '0) : r_mem[r_row + 1'b1];

  // x_l[j] = x[j-1], x_r[j] = x[j+1]
  assign w_al = {w_above[COLS-2:0], WRAP_B & w_above[COLS-1]};
  assign w_ar = {WRAP_B & w_above[0], w_above[COLS-1:1]};
  assign w_cl = {w_cur[COLS-2:0],   WRAP_B & w_cur[COLS-1]};
  assign w_cr = {WRAP_B & w_cur[0],   w_cur[COLS-1:1]};
  assign w_bl = {w_below[COLS-2:0], WRAP_B & w_below[COLS-1]};
  assign w_br = {WRAP_B & w_below[0], w_below[COLS-1:1]};

  for (genvar j = 0; j < COLS; j++) begin : g_cell
    logic [3:0] w_cnt;
    assign w_cnt = 4'(w_al[j]) + 4'(w_above[j]) + 4'(w_ar[j]) + 4'(w_cl[j]) +
                   4'(w_cr[j]) + 4'(w_bl[j]) + 4'(w_below[j]) + 4'(w_br[j]);
    assign w_new[j] = (w_cnt == 4'd3) || ((w_cnt == 4'd2) && w_cur[j]);
  end

  assign w_row_pop = PW'($countones(w_new));
  assign w_total   = (w_first_row ? '0 : r_acc) + w_row_pop;
  assign w_chg_tot = (~w_first_row & r_chg) | (w_new != w_cur);

  always_comb begin
    w_full_pop = '0;
    for (int i = 0; i < ROWS; i++) w_full_pop = w_full_pop + PW'($countones(r_mem[i]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (!clear && !seed_we && w_start) w_state_nxt = CALC;
      CALC: if (w_last) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) r_mem[i] <= '0;
      r_prev     <= '0;
      r_first    <= '0;
      r_row      <= '0;
      r_acc      <= '0;
      r_chg      <= 1'b0;
      r_pop      <= '0;
      r_pop_pend <= 1'b0;
      r_gen      <= '0;
      r_gen_done <= 1'b0;
      r_ext      <= 1'b0;
      r_stb      <= 1'b0;
    end else begin
      r_gen_done <= 1'b0;
      if (r_state == IDLE) begin
        r_row <= '0;
        if (clear) begin
          for (int i = 0; i < ROWS; i++) r_mem[i] <= '0;
          r_gen      <= '0;
          r_pop      <= '0;
          r_ext      <= 1'b0;
          r_stb      <= 1'b0;
          r_pop_pend <= 1'b0;
        end else begin
          // Popcount of seeded array is taken one cycle after the write lands.
          if (r_pop_pend) r_pop <= w_full_pop;
          r_pop_pend <= 1'b0;
          if (w_seed_ok) begin
            r_mem[seed_row] <= seed_data;
            r_ext           <= 1'b0;
            r_stb           <= 1'b0;
            r_pop_pend      <= 1'b1;
          end
        end
      end else begin
        r_mem[r_row] <= w_new;
        r_prev       <= w_cur;
        if (w_first_row) r_first <= w_cur;
        r_acc <= w_total;
        r_chg <= w_chg_tot;
        r_row <= r_row + 1'b1;
        if (w_last) begin
          r_gen_done <= 1'b1;
          r_gen      <= r_gen + 1'b1;
          r_pop      <= w_total;
          r_ext      <= (w_total == '0);
          r_stb      <= ~w_chg_tot;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_rd <= '0;
    else if ({1'b0, rd_row} < ROWS_L)   r_rd <= r_mem[rd_row];
    else                                r_rd <= '0;
  end

  assign rd_data   = r_rd;
  assign busy      = (r_state == CALC);
  assign gen_done  = r_gen_done;
  assign gen_count = r_gen;
  assign pop_count = r_pop;
  assign extinct   = r_ext;
  assign stable    = r_stb;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: a bounded-edge and a toroidal instance share stimulus; a scoreboard checks each commit.
module tb_life_engine;
  localparam int ROWS = 24, COLS = 32, GEN_W = 16, RW = 5, PW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, run_en, step_tick, single_step, clear, seed_we;
  logic [RW-1:0]    seed_row, rd_row;
  logic [COLS-1:0]  seed_data;
  logic [COLS-1:0]  rd_data0, rd_data1;
  logic             busy0, busy1, gen_done0, gen_done1;
  logic [GEN_W-1:0] gen_count0, gen_count1;
  logic [PW-1:0]    pop0, pop1;
  logic             extinct0, extinct1, stable0, stable1;

  life_engine #(.COLS(COLS), .ROWS(ROWS), .WRAP(0), .GEN_W(GEN_W)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .run_en(run_en), .step_tick(step_tick),
    .single_step(single_step), .clear(clear), .seed_we(seed_we), .seed_row(seed_row),
    .seed_data(seed_data), .rd_row(rd_row), .rd_data(rd_data0), .busy(busy0),
    .gen_done(gen_done0), .gen_count(gen_count0), .pop_count(pop0),
    .extinct(extinct0), .stable(stable0));

  life_engine #(.COLS(COLS), .ROWS(ROWS), .WRAP(1), .GEN_W(GEN_W)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .run_en(run_en), .step_tick(step_tick),
    .single_step(single_step), .clear(clear), .seed_we(seed_we), .seed_row(seed_row),
    .seed_data(seed_data), .rd_row(rd_row), .rd_data(rd_data1), .busy(busy1),
    .gen_done(gen_done1), .gen_count(gen_count1), .pop_count(pop1),
    .extinct(extinct1), .stable(stable1));

  typedef struct packed {
    logic [GEN_W-1:0] gen;
    logic [PW-1:0]    pop;
    logic             ext;
    logic             stb;
  } exp_t;

  // Reference grids: index 0 = dead border, index 1 = toroidal
  logic [COLS-1:0]  m_g [2][ROWS];
  logic [GEN_W-1:0] m_gen [2];
  int               m_pop [2];
  bit               m_ext [2], m_stb [2];
  exp_t             q0[$], q1[$];
  exp_t             e0, e1;
  int               n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cell_at(input int k, input int r, input int c);
    if (k == 1) begin
      r = (r + ROWS) % ROWS;
      c = (c + COLS) % COLS;
    end else if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
      return 1'b0;
    end
    return m_g[k][r][c];
  endfunction

  function automatic void model_step(input int k);
    logic [COLS-1:0] nx [ROWS];
    int n, p;
    bit chg;
    p = 0;
    chg = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += int'(cell_at(k, r + dr, c + dc));
        nx[r][c] = (n == 3) || (n == 2 && m_g[k][r][c]);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (nx[r] != m_g[k][r]) chg = 1;
      p += $countones(nx[r]);
      m_g[k][r] = nx[r];
    end
    m_gen[k] = m_gen[k] + 1'b1;
    m_pop[k] = p;
    m_ext[k] = (p == 0);
    m_stb[k] = !chg;
  endfunction

  function automatic exp_t model_exp(input int k);
    exp_t e;
    e.gen = m_gen[k];
    e.pop = PW'(m_pop[k]);
    e.ext = m_ext[k];
    e.stb = m_stb[k];
    return e;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < ROWS; r++) m_g[k][r] = '0;
      m_gen[k] = '0;
      m_pop[k] = 0;
      m_ext[k] = 0;
      m_stb[k] = 0;
    end
  endfunction

  // Scoreboard monitor: every commit pulse pops one expected result
  always @(negedge clk) begin
    if (reset_n) begin
      if (gen_done0) begin
        if (q0.size() == 0) check("unexpected_done0", 1, 0);
        else begin
          e0 = q0.pop_front();
          check("commit0", {gen_count0, pop0, extinct0, stable0}, e0);
        end
      end
      if (gen_done1) begin
        if (q1.size() == 0) check("unexpected_done1", 1, 0);
        else begin
          e1 = q1.pop_front();
          check("commit1", {gen_count1, pop1, extinct1, stable1}, e1);
        end
      end
    end
  end

  task automatic seed(input int r, input logic [COLS-1:0] d);
    seed_we   = 1'b1;
    seed_row  = RW'(r);
    seed_data = d;
    for (int k = 0; k < 2; k++) begin
      m_g[k][r] = d;
      m_ext[k]  = 0;
      m_stb[k]  = 0;
    end
    @(negedge clk);
    seed_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_clear();
    @(negedge clk);
    clear = 1'b0;
  endtask

  // use_tick: step_tick with run_en, else single_step. inject: pulse clear+seed mid-CALC.
  task automatic pulse_start(input bit use_tick, input bit inject);
    bit st [2];
    int b  [2];
    bit d  [2];
    if (use_tick) begin run_en = 1'b1; step_tick = 1'b1; end
    else single_step = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st[k] = !use_tick || (!m_ext[k] && !m_stb[k]);
      b[k] = 0;
      d[k] = 0;
      if (st[k]) begin
        model_step(k);
        if (k == 0) q0.push_back(model_exp(0));
        else        q1.push_back(model_exp(1));
      end
    end
    @(negedge clk);
    step_tick = 1'b0;
    single_step = 1'b0;
    for (int c = 0; c < ROWS + 4; c++) begin
      if (busy0) b[0]++;
      else if (st[0] && b[0] == ROWS && !d[0]) begin check("done0_latency", gen_done0, 1); d[0] = 1; end
      if (busy1) b[1]++;
      else if (st[1] && b[1] == ROWS && !d[1]) begin check("done1_latency", gen_done1, 1); d[1] = 1; end
      if (inject && c == 5) begin
        clear = 1'b1; seed_we = 1'b1; seed_row = 6; seed_data = '1;
      end else begin
        clear = 1'b0; seed_we = 1'b0;
      end
      @(negedge clk);
    end
    check("busy0_len", b[0], st[0] ? ROWS : 0);
    check("busy1_len", b[1], st[1] ? ROWS : 0);
  endtask

  task automatic read_row(input int r, output logic [COLS-1:0] d0, output logic [COLS-1:0] d1);
    rd_row = RW'(r);
    @(negedge clk);
    d0 = rd_data0;
    d1 = rd_data1;
  endtask

  task automatic check_grid(input string name);
    logic [COLS-1:0] d0, d1;
    int bad0, bad1;
    bad0 = 0;
    bad1 = 0;
    for (int r = 0; r < ROWS; r++) begin
      read_row(r, d0, d1);
      if (d0 !== m_g[0][r]) bad0++;
      if (d1 !== m_g[1][r]) bad1++;
    end
    check({name, "_grid0_badrows"}, bad0, 0);
    check({name, "_grid1_badrows"}, bad1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [COLS-1:0] d0, d1;
    reset_n = 1'b0; run_en = 1'b0; step_tick = 1'b0; single_step = 1'b0;
    clear = 1'b0; seed_we = 1'b0; seed_row = '0; seed_data = '0; rd_row = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_out0", {busy0, gen_done0, gen_count0, pop0, extinct0, stable0, rd_data0}, 0);
    check("reset_out1", {busy1, gen_done1, gen_count1, pop1, extinct1, stable1, rd_data1}, 0);

    // Vertical blinker -> horizontal
    seed(5, 32'h0000_0400);
    seed(6, 32'h0000_0400);
    seed(7, 32'h0000_0400);
    @(negedge clk);
    check("seed_pop", pop0, 3);
    pulse_start(0, 0);
    read_row(5, d0, d1); check("blink_r5", d0, 32'h0);
    read_row(6, d0, d1); check("blink_r6", d0, 32'h0000_0E00);
    read_row(7, d0, d1); check("blink_r7", d0, 32'h0);
    check("blink_gen_pop_stb", {gen_count0, pop0, stable0}, {16'd1, 10'd3, 1'b0});

    // clear and seed during CALC must be dropped
    pulse_start(0, 1);
    read_row(6, d0, d1); check("blink_back_r6", d0, 32'h0000_0400);
    check_grid("inject");

    // start coinciding with clear: array cleared, no generation
    clear = 1'b1; single_step = 1'b1;
    model_clear();
    @(negedge clk);
    clear = 1'b0; single_step = 1'b0;
    check("clear_start_busy", {busy0, busy1}, 0);
    @(negedge clk);
    check("clear_counts", {gen_count0, pop0, gen_count1, pop1}, 0);
    check_grid("clear");

    // Lone cell dies; further ticks ignored; seeding clears extinct
    seed(3, 32'h0000_0080);
    @(negedge clk);
    pulse_start(1, 0);
    check("lone_extinct", {pop0, extinct0, extinct1}, {10'd0, 1'b1, 1'b1});
    pulse_start(1, 0);
    check("extinct_gen_hold", gen_count0, 1);
    seed(0, 32'h0);
    @(negedge clk);
    check("seed_clears_extinct", {extinct0, extinct1}, 0);
    run_en = 1'b0;

    // Still life: stable gates step_tick, single_step still runs
    do_clear();
    seed(2, 32'h0000_0030);
    seed(3, 32'h0000_0030);
    @(negedge clk);
    pulse_start(0, 0);
    check("block_stable", {pop0, stable0, extinct0}, {10'd4, 1'b1, 1'b0});
    pulse_start(1, 0);
    check("block_tick_ignored", gen_count0, 1);
    pulse_start(0, 0);
    check("block_single_step", gen_count0, 2);
    run_en = 1'b0;

    // Glider heading down-right on both edge modes
    do_clear();
    seed(0, 32'h0000_0200);
    seed(1, 32'h0000_0400);
    seed(2, 32'h0000_0700);
    @(negedge clk);
    for (int g = 0; g < 130; g++) begin
      pulse_start(1, 0);
      if (g % 16 == 15) check_grid("glider");
    end
    check("glider_wrap_pop", pop1, 5);
    check("glider_wrap_gen", gen_count1, 130);
    check("glider_bounded_stable", stable0, m_stb[0]);
    check_grid("glider_end");
    run_en = 1'b0;

    // Reset in the middle of a generation
    seed(10, 32'hFFFF_0000);
    @(negedge clk);
    single_step = 1'b1;
    @(negedge clk);
    single_step = 1'b0;
    repeat (9) @(negedge clk);
    check("midcalc_busy", busy0, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_out0", {busy0, gen_done0, gen_count0, pop0, extinct0, stable0, rd_data0}, 0);
    check("midrst_out1", {busy1, gen_done1, gen_count1, pop1, extinct1, stable1, rd_data1}, 0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_grid("after_reset");
    check("after_reset_busy", {busy0, busy1}, 0);

    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
